// File: rtl/iob_pfsm_timed_if.sv
// IOb-native CSR bus bundle for iob_pfsm_timed; the peripheral side uses the slave modport.
interface iob_pfsm_timed_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 8
);
  logic                iob_valid_i;
  logic [ADDR_W-1:0]   iob_addr_i;
  logic [DATA_W-1:0]   iob_wdata_i;
  logic [DATA_W/8-1:0] iob_wstrb_i;
  logic                iob_ready_o;
  logic                iob_rvalid_o;
  logic [DATA_W-1:0]   iob_rdata_o;

  modport master (
    output iob_valid_i, iob_addr_i, iob_wdata_i, iob_wstrb_i,
    input  iob_ready_o, iob_rvalid_o, iob_rdata_o
  );

  modport slave (
    input  iob_valid_i, iob_addr_i, iob_wdata_i, iob_wstrb_i,
    output iob_ready_o, iob_rvalid_o, iob_rdata_o
  );
endinterface

// File: rtl/iob_pfsm_timed.sv
// Timed programmable FSM: LUT {dwell, next_state, outputs} indexed by {state, inputs}, CSR-controlled.
// Optional IOB_PFSM_TIMED_INPUT_SYNC_EN adds a 2-flop synchronizer on input_ports_i.
module iob_pfsm_timed #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned STATE_W  = 2,
  parameter int unsigned INPUT_W  = 1,
  parameter int unsigned OUTPUT_W = 1,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned TCNT_W   = 16
) (
  input  logic                clk_i,
  input  logic                cke_i,
  input  logic                arst_i,
  iob_pfsm_timed_if.slave     iob,
  input  logic [INPUT_W-1:0]  input_ports_i,
  output logic [OUTPUT_W-1:0] output_ports_o
);
  localparam int unsigned LUT_W  = CNT_W + STATE_W + OUTPUT_W;
  localparam int unsigned NWORDS = (LUT_W + DATA_W - 1) / DATA_W;
  localparam int unsigned WSEL_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int unsigned PAD_W  = NWORDS * DATA_W;
  localparam int unsigned IDX_W  = STATE_W + INPUT_W;
  localparam int unsigned NENT   = 2 ** IDX_W;
  localparam int unsigned RIDX_W = ADDR_W - 3;
  localparam logic [PAD_W:0]    LUT_TOP  = (PAD_W + 1)'(1) << LUT_W;
  localparam logic [PAD_W-1:0]  LUT_MASK = PAD_W'(LUT_TOP - (PAD_W + 1)'(1));
  localparam logic [RIDX_W-1:0] R_CTRL   = RIDX_W'(0);
  localparam logic [RIDX_W-1:0] R_WSEL   = RIDX_W'(1);
  localparam logic [RIDX_W-1:0] R_STATUS = RIDX_W'(2);
  localparam logic [RIDX_W-1:0] R_TCNT   = RIDX_W'(3);

  typedef enum logic [1:0] {SEQ_STOP, SEQ_EVAL, SEQ_DWELL} seq_e;
  seq_e seq;

  logic [STATE_W-1:0]  state_q, state_d;
  logic [OUTPUT_W-1:0] out_q, out_d;
  logic [CNT_W-1:0]    dwell_q, dwell_d;
  logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
  logic                run_q, run_d;
  logic                step_q, step_d;
  logic [WSEL_W-1:0]   wsel_q, wsel_d;
  logic                rvalid_q, rvalid_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [PAD_W-1:0]    lut_q [NENT];

  logic [INPUT_W-1:0]  in_eff;
  logic [LUT_W-1:0]    lk_w;
  logic [PAD_W-1:0]    lut_rword;
  logic [DATA_W-1:0]   lut_rslice;
  logic                req, wr, rd, lut_sel, ctrl_we, wsel_we;
  logic [RIDX_W-1:0]   reg_idx;
  logic [IDX_W-1:0]    lut_idx;
  logic                addr_unused;

`ifdef IOB_PFSM_TIMED_INPUT_SYNC_EN
  logic [INPUT_W-1:0] sync1_q, sync2_q;
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else if (cke_i) begin
      sync1_q <= input_ports_i;
      sync2_q <= sync1_q;
    end
  end
  assign in_eff = sync2_q;
`else
  assign in_eff = input_ports_i;
`endif

  assign req         = cke_i & iob.iob_valid_i;
  assign wr          = req & (|iob.iob_wstrb_i);
  assign rd          = req & ~(|iob.iob_wstrb_i);
  assign lut_sel     = iob.iob_addr_i[ADDR_W-1];
  assign reg_idx     = iob.iob_addr_i[ADDR_W-2:2];
  assign lut_idx     = iob.iob_addr_i[2 +: IDX_W];
  assign ctrl_we     = wr & ~lut_sel & (reg_idx == R_CTRL);
  assign wsel_we     = wr & ~lut_sel & (reg_idx == R_WSEL);
  assign addr_unused = ^iob.iob_addr_i[1:0];

  assign lk_w      = lut_q[{state_q, in_eff}][LUT_W-1:0];
  assign lut_rword = lut_q[lut_idx] & LUT_MASK;

  always_comb begin
    lut_rslice = '0;
    for (int unsigned k = 0; k < NWORDS; k++) begin
      if (wsel_q == WSEL_W'(k)) lut_rslice = lut_rword[k*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr && lut_sel) begin
      for (int unsigned k = 0; k < NWORDS; k++) begin
        if (wsel_q == WSEL_W'(k)) lut_q[lut_idx][k*DATA_W +: DATA_W] <= iob.iob_wdata_i;
      end
    end
  end

  always_comb begin
    seq      = SEQ_STOP;
    state_d  = state_q;
    out_d    = out_q;
    dwell_d  = dwell_q;
    tcnt_d   = tcnt_q;
    run_d    = run_q;
    step_d   = 1'b0;
    wsel_d   = wsel_q;
    rvalid_d = rd;
    rdata_d  = rdata_q;

    if (dwell_q != '0)        seq = SEQ_DWELL;
    else if (run_q || step_q) seq = SEQ_EVAL;

    unique case (seq)
      SEQ_EVAL: begin
        out_d   = lk_w[OUTPUT_W-1:0];
        state_d = lk_w[OUTPUT_W +: STATE_W];
        dwell_d = lk_w[OUTPUT_W+STATE_W +: CNT_W];
        tcnt_d  = (&tcnt_q) ? tcnt_q : tcnt_q + TCNT_W'(1);
      end
      SEQ_DWELL: dwell_d = dwell_q - CNT_W'(1);
      default: ;
    endcase

    // A soft reset in the same write overrides this cycle's evaluation and drops STEP.
    if (ctrl_we) begin
      run_d = iob.iob_wdata_i[0];
      if (iob.iob_wdata_i[1]) begin
        state_d = '0;
        out_d   = '0;
        dwell_d = '0;
        tcnt_d  = '0;
      end else begin
        step_d = iob.iob_wdata_i[2];
      end
    end

    if (wsel_we && (NWORDS > 1)) wsel_d = iob.iob_wdata_i[WSEL_W-1:0];

    if (rd) begin
      rdata_d = '0;
      if (lut_sel) begin
        rdata_d = lut_rslice;
      end else begin
        case (reg_idx)
          R_WSEL:   rdata_d = DATA_W'(wsel_q);
          R_STATUS: rdata_d = DATA_W'({dwell_q, run_q, state_q});
          R_TCNT:   rdata_d = DATA_W'(tcnt_q);
          default:  rdata_d = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q  <= '0;
      out_q    <= '0;
      dwell_q  <= '0;
      tcnt_q   <= '0;
      run_q    <= 1'b0;
      step_q   <= 1'b0;
      wsel_q   <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else if (cke_i) begin
      state_q  <= state_d;
      out_q    <= out_d;
      dwell_q  <= dwell_d;
      tcnt_q   <= tcnt_d;
      run_q    <= run_d;
      step_q   <= step_d;
      wsel_q   <= wsel_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  assign iob.iob_ready_o  = 1'b1;
  assign iob.iob_rvalid_o = rvalid_q;
  assign iob.iob_rdata_o  = rdata_q;
  assign output_ports_o   = out_q;
endmodule

// File: tb/tb_iob_pfsm_timed.sv
// Randomized self-checking bench for iob_pfsm_timed against a transaction-level reference model.
module tb_iob_pfsm_timed;
  logic clk_i = 1'b0;
  logic cke_i;
  logic arst_i;
  logic [0:0] input_ports_i;
  logic [0:0] out1, out2;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  iob_pfsm_timed_if #(.DATA_W(32), .ADDR_W(8)) bus ();
  iob_pfsm_timed_if #(.DATA_W(32), .ADDR_W(8)) bus2 ();

  iob_pfsm_timed #(.DATA_W(32), .ADDR_W(8), .STATE_W(2), .INPUT_W(1), .OUTPUT_W(1),
                   .CNT_W(8), .TCNT_W(16)) dut (
    .clk_i(clk_i), .cke_i(cke_i), .arst_i(arst_i), .iob(bus),
    .input_ports_i(input_ports_i), .output_ports_o(out1));

  iob_pfsm_timed #(.DATA_W(32), .ADDR_W(8), .STATE_W(2), .INPUT_W(1), .OUTPUT_W(1),
                   .CNT_W(8), .TCNT_W(2)) dut2 (
    .clk_i(clk_i), .cke_i(cke_i), .arst_i(arst_i), .iob(bus2),
    .input_ports_i(input_ports_i), .output_ports_o(out2));

  always #5 clk_i = ~clk_i;

  // Reference model of dut: whole-transaction view with integer fields.
  int unsigned lut_m [8];
  int unsigned m_state, m_out, m_dwell, m_tcnt, m_run, m_step, m_sync1, m_sync2, m_rexp;
  bit m_rvalid;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_out = 0; m_dwell = 0; m_tcnt = 0; m_run = 0; m_step = 0;
    m_sync1 = 0; m_sync2 = 0; m_rvalid = 0; m_rexp = 0;
  endtask

  function automatic int unsigned model_read(input int unsigned a);
    if (a >= 128) return lut_m[(a >> 2) & 7];
    case ((a >> 2) & 31)
      2:       return (m_dwell << 3) | (m_run << 2) | m_state;
      3:       return m_tcnt;
      default: return 0;
    endcase
  endfunction

  task automatic model_edge();
    int unsigned in_use, e, a, d;
    int unsigned n_state, n_out, n_dwell, n_tcnt, n_run, n_step;
    if (!cke_i) return;
`ifdef IOB_PFSM_TIMED_INPUT_SYNC_EN
    in_use = m_sync2;
`else
    in_use = int'(input_ports_i);
`endif
    n_state = m_state; n_out = m_out; n_dwell = m_dwell; n_tcnt = m_tcnt;
    n_run = m_run; n_step = 0;
    if (m_dwell != 0) begin
      n_dwell = m_dwell - 1;
    end else if (m_run != 0 || m_step != 0) begin
      e = lut_m[m_state * 2 + in_use];
      n_out = e & 1;
      n_state = (e >> 1) & 3;
      n_dwell = e >> 3;
      if (m_tcnt < 65535) n_tcnt = m_tcnt + 1;
    end
    m_rvalid = 0;
    if (bus.iob_valid_i) begin
      a = int'(bus.iob_addr_i);
      d = bus.iob_wdata_i;
      if (bus.iob_wstrb_i != 0) begin
        if (a >= 128) lut_m[(a >> 2) & 7] = d & 32'h7ff;
        else if (((a >> 2) & 31) == 0) begin
          n_run = d & 1;
          if ((d & 2) != 0) begin
            n_state = 0; n_out = 0; n_dwell = 0; n_tcnt = 0;
          end else n_step = (d >> 2) & 1;
        end
      end else begin
        m_rvalid = 1;
        m_rexp = model_read(a);
      end
    end
    m_sync2 = m_sync1;
    m_sync1 = int'(input_ports_i);
    m_state = n_state; m_out = n_out; m_dwell = n_dwell; m_tcnt = n_tcnt;
    m_run = n_run; m_step = n_step;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk_i);
    #1;
    chk("out", 64'(out1), 64'(m_out));
    chk("rvalid", 64'(bus.iob_rvalid_o), 64'(m_rvalid));
    if (m_rvalid) chk("rdata", 64'(bus.iob_rdata_o), 64'(m_rexp));
  endtask

  task automatic bus_idle();
    bus.iob_valid_i = 1'b0;  bus.iob_wstrb_i = '0;  bus.iob_addr_i = '0;  bus.iob_wdata_i = '0;
    bus2.iob_valid_i = 1'b0; bus2.iob_wstrb_i = '0; bus2.iob_addr_i = '0; bus2.iob_wdata_i = '0;
  endtask

  task automatic csr_write(input bit d2, input int unsigned addr, input int unsigned data);
    if (d2) begin
      bus2.iob_valid_i = 1'b1; bus2.iob_addr_i = 8'(addr);
      bus2.iob_wdata_i = data; bus2.iob_wstrb_i = '1;
    end else begin
      bus.iob_valid_i = 1'b1; bus.iob_addr_i = 8'(addr);
      bus.iob_wdata_i = data; bus.iob_wstrb_i = '1;
    end
    tick();
    bus_idle();
  endtask

  task automatic csr_read(input bit d2, input int unsigned addr, output logic [31:0] data);
    if (d2) begin
      bus2.iob_valid_i = 1'b1; bus2.iob_addr_i = 8'(addr);
    end else begin
      bus.iob_valid_i = 1'b1; bus.iob_addr_i = 8'(addr);
    end
    tick();
    data = d2 ? bus2.iob_rdata_o : bus.iob_rdata_o;
    if (d2) chk("rvalid2", 64'(bus2.iob_rvalid_o), 64'(1));
    bus_idle();
  endtask

  function automatic int unsigned count_word(input int unsigned idx);
    int unsigned s = idx >> 1;
    if ((idx & 1) != 0) return (((s + 1) % 4) << 1) | (s & 1);
    return s << 1;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int unsigned sel, idx, v;
    bus_idle();
    cke_i = 1'b1;
    arst_i = 1'b1;
    input_ports_i = 1'b0;
    for (int unsigned i = 0; i < 8; i++) lut_m[i] = 0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #3 arst_i = 1'b0;

    chk("reset_out", 64'(out1), 64'(0));
    chk("reset_rvalid", 64'(bus.iob_rvalid_o), 64'(0));
    csr_read(0, 8'h08, rd); chk("reset_status", 64'(rd), 64'(0));
    csr_read(0, 8'h0C, rd); chk("reset_tcnt", 64'(rd), 64'(0));

    for (int unsigned i = 0; i < 8; i++) csr_write(0, 128 + i * 4, count_word(i));

    // Count 0,1,2,3,0 with input held high.
    input_ports_i = 1'b1;
    csr_write(0, 8'h00, 1);
    repeat (5) tick();
    csr_read(0, 8'h0C, rd); chk("count_tcnt5", 64'(rd), 64'(5));

    // Dwell: state 1 held four cycles, inputs ignored.
    csr_write(0, 8'h00, 2);
    csr_write(0, 128 + 0, (3 << 3) | (1 << 1) | 1);
    csr_write(0, 128 + 4, (3 << 3) | (1 << 1) | 1);
    csr_write(0, 128 + 8, 2 << 1);
    csr_write(0, 128 + 12, 2 << 1);
    csr_write(0, 8'h00, 1);
    tick();
    for (int unsigned k = 0; k < 4; k++) begin
      input_ports_i = 1'($urandom);
      csr_read(0, 8'h08, rd);
      chk("dwell_status", 64'(rd), 64'(((3 - k) << 3) | 4 | 1));
    end

    // Single-step from stopped state.
    csr_write(0, 8'h00, 2);
    for (int unsigned i = 0; i < 4; i++) csr_write(0, 128 + i * 4, count_word(i));
    for (int unsigned k = 0; k < 3; k++) begin
      input_ports_i = 1'($urandom);
      csr_write(0, 8'h00, 4);
      tick();
      tick();
    end
    csr_read(0, 8'h0C, rd); chk("step_tcnt3", 64'(rd), 64'(3));
    repeat (3) tick();
    csr_read(0, 8'h0C, rd); chk("step_hold", 64'(rd), 64'(3));

    csr_write(0, 8'h00, 1);
    repeat (2) tick();
    csr_write(0, 8'h00, 5);
    repeat (2) tick();
    csr_read(0, 8'h0C, rd);

    csr_write(0, 8'h00, 3);
    csr_read(0, 8'h0C, rd); chk("softreset_tcnt", 64'(rd), 64'(0));
    csr_read(0, 8'h08, rd); chk("softreset_run", 64'(rd[2]), 64'(1));
    csr_write(0, 8'h00, 6);
    repeat (3) tick();
    csr_read(0, 8'h0C, rd); chk("sr_step_tcnt", 64'(rd), 64'(0));
    csr_read(0, 8'h08, rd); chk("sr_step_status", 64'(rd), 64'(0));

    v = $urandom;
    csr_write(0, 128 + 5 * 4, v);
    csr_read(0, 128 + 5 * 4, rd); chk("lut_readback", 64'(rd), 64'(v & 32'h7ff));
    tick();
    chk("rvalid_pulse", 64'(bus.iob_rvalid_o), 64'(0));
    csr_write(0, 8'h04, 1);
    csr_read(0, 8'h04, rd); chk("wordsel", 64'(rd), 64'(0));
    for (int unsigned i = 0; i < 8; i++) csr_write(0, 128 + i * 4, count_word(i));

    // Clock enable low freezes everything and drops requests.
    csr_write(0, 8'h00, 1);
    repeat (2) tick();
    cke_i = 1'b0;
    bus.iob_valid_i = 1'b1; bus.iob_addr_i = 8'h00; bus.iob_wdata_i = 2; bus.iob_wstrb_i = '1;
    repeat (3) tick();
    bus_idle();
    cke_i = 1'b1;
    csr_read(0, 8'h08, rd);

    for (int unsigned it = 0; it < 400; it++) begin
      input_ports_i = 1'($urandom);
      sel = $urandom_range(0, 99);
      if (sel < 60) tick();
      else if (sel < 75) csr_write(0, 128 + $urandom_range(0, 7) * 4,
                                   ($urandom_range(0, 3) << 3) | $urandom_range(0, 7));
      else if (sel < 85) csr_write(0, 8'h00, $urandom_range(0, 7));
      else if (sel < 98) begin
        idx = $urandom_range(0, 4);
        case (idx)
          0: csr_read(0, 8'h04, rd);
          1: csr_read(0, 8'h08, rd);
          2: csr_read(0, 8'h0C, rd);
          3: csr_read(0, 8'h10, rd);
          default: csr_read(0, 128 + $urandom_range(0, 7) * 4, rd);
        endcase
      end else begin
        cke_i = 1'b0;
        tick();
        cke_i = 1'b1;
      end
    end

    arst_i = 1'b1;
    model_reset();
    #2 arst_i = 1'b0;
    chk("arst_out", 64'(out1), 64'(0));
    chk("arst_rvalid", 64'(bus.iob_rvalid_o), 64'(0));
    csr_read(0, 8'h08, rd); chk("arst_status", 64'(rd), 64'(0));
    csr_read(0, 8'h0C, rd); chk("arst_tcnt", 64'(rd), 64'(0));

    // Narrow transition counter saturates at all-ones.
    for (int unsigned i = 0; i < 8; i++) csr_write(1, 128 + i * 4, 0);
    csr_write(1, 8'h00, 1);
    repeat (6) tick();
    csr_read(1, 8'h0C, rd); chk("tcnt_saturate", 64'(rd), 64'(3));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
